jpeg_mcu_gather: RTL and testbench

- Sits directly downstream of the IDCT/MCU-ID stage.
- Collects tagged 8x8 sample blocks (Y, Cb, Cr) into a per-MCU buffer.
- Once an MCU is complete, drains it as a raster-ordered pixel stream of {Y, Cb, Cr} triples with absolute image coordinates.
- Upsamples 4:2:0 chroma by index mapping and crops pixels outside the image; feeds the colour-space converter.

---
 rtl/jpeg_gather_pkg.sv | 30 +++
 rtl/jpeg_gather_ram.sv | 24 ++
 rtl/jpeg_mcu_gather.sv | 177 +++++++++++++++++
 tb/tb_jpeg_mcu_gather.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_gather_pkg.sv
// Shared constants for the JPEG MCU gather stage: colour modes, block tags,
// FSM encoding and the per-MCU sample buffer layout.
package jpeg_gather_pkg;

  localparam logic [1:0] JPEG_MONOCHROME = 2'd0;
  localparam logic [1:0] YCBCR_444       = 2'd1;
  localparam logic [1:0] YCBCR_420       = 2'd2;
  localparam logic [1:0] UNSUPPORTED     = 2'd3;

  localparam logic [1:0] BLOCK_Y   = 2'd0;
  localparam logic [1:0] BLOCK_CB  = 2'd1;
  localparam logic [1:0] BLOCK_CR  = 2'd2;
  localparam logic [1:0] BLOCK_EOF = 2'd3;

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  localparam int BUF_DEPTH  = 384;
  localparam int BUF_ADDR_W = 9;

  localparam logic [8:0] Y_BASE  = 9'd0;
  localparam logic [8:0] CB_BASE = 9'd256;
  localparam logic [8:0] CR_BASE = 9'd320;

  // Luma offset inside the four Y slots: slot = (py>>3)*2 + (px>>3), then row/col.
  function automatic logic [7:0] y_offset(input logic [3:0] px, input logic [3:0] py);
    return {py[3], px[3], py[2:0], px[2:0]};
  endfunction

endpackage

// File: rtl/jpeg_gather_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with
// registered read data and a read enable so the output can be held.
module jpeg_gather_ram #(
  parameter int SAMPLE_W = 8,
  parameter int DEPTH    = 384,
  parameter int ADDR_W   = 9
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/jpeg_mcu_gather.sv
// Gathers tagged 8x8 Y/Cb/Cr blocks into one MCU buffer, then drains the MCU as a
// raster pixel stream with 4:2:0 chroma upsampling and image-edge cropping.
module jpeg_mcu_gather
  import jpeg_gather_pkg::*;
#(
  parameter int SAMPLE_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                img_start_i,
  input  logic [1:0]          img_mode_i,
  input  logic [15:0]         img_width_i,
  input  logic [15:0]         img_height_i,
  input  logic                inport_valid_i,
  input  logic [SAMPLE_W-1:0] inport_data_i,
  input  logic [5:0]          inport_idx_i,
  input  logic [31:0]         inport_id_i,
  output logic                inport_accept_o,
  output logic                outport_valid_o,
  input  logic                outport_accept_i,
  output logic [SAMPLE_W-1:0] outport_y_o,
  output logic [SAMPLE_W-1:0] outport_cb_o,
  output logic [SAMPLE_W-1:0] outport_cr_o,
  output logic [15:0]         outport_px_x_o,
  output logic [15:0]         outport_px_y_o,
  output logic                mcu_done_o
);

  localparam logic [SAMPLE_W-1:0] CHROMA_MID = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [0:0]          state;
  logic [5:0]          samp_cnt;
  logic [1:0]          y_cnt;
  logic [15:0]         org_x, org_y;
  logic [3:0]          px, py;
  logic                issue_done;
  logic                s1_valid, s1_crop, s1_last;
  logic [15:0]         s1_x, s1_y;
  logic                out_busy, out_last, out_valid, mcu_done;
  logic [SAMPLE_W-1:0] y_reg, cb_reg, cr_reg;
  logic [15:0]         x_reg, yc_reg;

  logic [1:0]          blk_type;
  logic                is_420, store, blk_end, mcu_full;
  logic [8:0]          wr_addr, y_rd_addr, cb_rd_addr, cr_rd_addr;
  logic [5:0]          c_idx;
  logic [3:0]          pos_lim;
  logic                last_pos, crop, stall, issuing, drain_end;
  logic [15:0]         cur_x, cur_y;
  logic [SAMPLE_W-1:0] y_q, cb_q, cr_q;
  logic                unused_id;

  assign blk_type  = inport_id_i[31:30];
  assign is_420    = (img_mode_i == YCBCR_420);
  assign store     = (state == FILL) && inport_valid_i && (blk_type != BLOCK_EOF)
                     && (img_mode_i != UNSUPPORTED);
  assign blk_end   = store && (samp_cnt == 6'd63);
  assign mcu_full  = blk_end &&
                     (((img_mode_i == JPEG_MONOCHROME) && (blk_type == BLOCK_Y)) ||
                      ((img_mode_i != JPEG_MONOCHROME) && (blk_type == BLOCK_CR)));
  assign unused_id = ^{inport_id_i[29], inport_id_i[15:13]};

  always_comb begin
    wr_addr = Y_BASE + {1'b0, y_cnt, inport_idx_i};
    case (blk_type)
      BLOCK_CB: wr_addr = CB_BASE + {3'b000, inport_idx_i};
      BLOCK_CR: wr_addr = CR_BASE + {3'b000, inport_idx_i};
      default:  wr_addr = Y_BASE + {1'b0, y_cnt, inport_idx_i};
    endcase
  end

  // Drain addressing: chroma is replicated 2x2 in 4:2:0 by dropping the pixel LSBs.
  assign pos_lim    = is_420 ? 4'd15 : 4'd7;
  assign last_pos   = (px == pos_lim) && (py == pos_lim);
  assign cur_x      = org_x + {12'd0, px};
  assign cur_y      = org_y + {12'd0, py};
  assign crop       = (cur_x >= img_width_i) || (cur_y >= img_height_i);
  assign c_idx      = is_420 ? {py[3:1], px[3:1]} : {py[2:0], px[2:0]};
  assign y_rd_addr  = Y_BASE + {1'b0, y_offset(px, py)};
  assign cb_rd_addr = CB_BASE + {3'b000, c_idx};
  assign cr_rd_addr = CR_BASE + {3'b000, c_idx};

  assign stall      = out_valid && !outport_accept_i;
  assign issuing    = (state == DRAIN) && !issue_done;
  assign drain_end  = out_busy && out_last && !stall;

  jpeg_gather_ram #(.SAMPLE_W(SAMPLE_W), .DEPTH(BUF_DEPTH), .ADDR_W(BUF_ADDR_W)) u_ram_y (
    .clk(clk_i), .wr_en(store), .wr_addr(wr_addr), .wr_data(inport_data_i),
    .rd_en(!stall), .rd_addr(y_rd_addr), .rd_data(y_q)
  );

  jpeg_gather_ram #(.SAMPLE_W(SAMPLE_W), .DEPTH(BUF_DEPTH), .ADDR_W(BUF_ADDR_W)) u_ram_cb (
    .clk(clk_i), .wr_en(store), .wr_addr(wr_addr), .wr_data(inport_data_i),
    .rd_en(!stall), .rd_addr(cb_rd_addr), .rd_data(cb_q)
  );

  jpeg_gather_ram #(.SAMPLE_W(SAMPLE_W), .DEPTH(BUF_DEPTH), .ADDR_W(BUF_ADDR_W)) u_ram_cr (
    .clk(clk_i), .wr_en(store), .wr_addr(wr_addr), .wr_data(inport_data_i),
    .rd_en(!stall), .rd_addr(cr_rd_addr), .rd_data(cr_q)
  );

  // Three-stage drain (issue, RAM read, output register) that freezes as a whole on stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= FILL;      samp_cnt <= '0;  y_cnt <= '0;
      org_x <= '0;        org_y <= '0;     px <= '0;      py <= '0;
      issue_done <= 1'b0; s1_valid <= 1'b0; s1_crop <= 1'b0; s1_last <= 1'b0;
      s1_x <= '0;         s1_y <= '0;
      out_busy <= 1'b0;   out_last <= 1'b0; out_valid <= 1'b0; mcu_done <= 1'b0;
      y_reg <= '0;        cb_reg <= '0;    cr_reg <= '0;  x_reg <= '0;   yc_reg <= '0;
    end else if (img_start_i) begin
      state <= FILL;      samp_cnt <= '0;  y_cnt <= '0;
      org_x <= '0;        org_y <= '0;     px <= '0;      py <= '0;
      issue_done <= 1'b0; s1_valid <= 1'b0; s1_crop <= 1'b0; s1_last <= 1'b0;
      s1_x <= '0;         s1_y <= '0;
      out_busy <= 1'b0;   out_last <= 1'b0; out_valid <= 1'b0; mcu_done <= 1'b0;
      y_reg <= '0;        cb_reg <= '0;    cr_reg <= '0;  x_reg <= '0;   yc_reg <= '0;
    end else begin
      mcu_done <= 1'b0;
      if (store) begin
        samp_cnt <= samp_cnt + 6'd1;
        if ((blk_type == BLOCK_Y) && (y_cnt == 2'd0) && (samp_cnt == 6'd0)) begin
          org_x <= {inport_id_i[12:0], 3'b000};
          org_y <= {inport_id_i[28:16], 3'b000};
        end
        if (blk_end && (blk_type == BLOCK_Y)) y_cnt <= y_cnt + 2'd1;
        if (mcu_full) state <= DRAIN;
      end
      if (!stall) begin
        s1_valid <= issuing;
        if (issuing) begin
          s1_crop <= crop;
          s1_last <= last_pos;
          s1_x    <= cur_x;
          s1_y    <= cur_y;
          if (last_pos) begin
            issue_done <= 1'b1;
          end else if (px == pos_lim) begin
            px <= 4'd0;
            py <= py + 4'd1;
          end else begin
            px <= px + 4'd1;
          end
        end
        out_busy  <= s1_valid;
        out_last  <= s1_valid && s1_last;
        out_valid <= s1_valid && !s1_crop;
        if (s1_valid && !s1_crop) begin
          y_reg  <= y_q;
          cb_reg <= (img_mode_i == JPEG_MONOCHROME) ? CHROMA_MID : cb_q;
          cr_reg <= (img_mode_i == JPEG_MONOCHROME) ? CHROMA_MID : cr_q;
          x_reg  <= s1_x;
          yc_reg <= s1_y;
        end
      end
      if (drain_end) begin
        mcu_done   <= 1'b1;
        state      <= FILL;
        samp_cnt   <= '0;
        y_cnt      <= '0;
        px         <= '0;
        py         <= '0;
        issue_done <= 1'b0;
      end
    end
  end

  assign inport_accept_o = (state == FILL);
  assign outport_valid_o = out_valid;
  assign outport_y_o     = y_reg;
  assign outport_cb_o    = cb_reg;
  assign outport_cr_o    = cr_reg;
  assign outport_px_x_o  = x_reg;
  assign outport_px_y_o  = yc_reg;
  assign mcu_done_o      = mcu_done;

endmodule

// File: tb/tb_jpeg_mcu_gather.sv
// Self-checking bench for jpeg_mcu_gather: blocks are sent with random index order
// and the drained pixel stream is compared against an arithmetic MCU model.
module tb_jpeg_mcu_gather;
  import jpeg_gather_pkg::*;

  localparam int DRAIN_BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        img_start;
  logic [1:0]  img_mode;
  logic [15:0] img_width, img_height;
  logic        inport_valid;
  logic [7:0]  inport_data;
  logic [5:0]  inport_idx;
  logic [31:0] inport_id;
  logic        inport_accept;
  logic        outport_valid;
  logic        outport_accept;
  logic [7:0]  outport_y, outport_cb, outport_cr;
  logic [15:0] outport_px_x, outport_px_y;
  logic        mcu_done;

  always #5 clk = ~clk;

  jpeg_mcu_gather #(.SAMPLE_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .img_start_i(img_start), .img_mode_i(img_mode),
    .img_width_i(img_width), .img_height_i(img_height),
    .inport_valid_i(inport_valid), .inport_data_i(inport_data), .inport_idx_i(inport_idx),
    .inport_id_i(inport_id), .inport_accept_o(inport_accept),
    .outport_valid_o(outport_valid), .outport_accept_i(outport_accept),
    .outport_y_o(outport_y), .outport_cb_o(outport_cb), .outport_cr_o(outport_cr),
    .outport_px_x_o(outport_px_x), .outport_px_y_o(outport_px_y), .mcu_done_o(mcu_done)
  );

  typedef struct packed {
    logic [7:0]  y;
    logic [7:0]  cb;
    logic [7:0]  cr;
    logic [15:0] x;
    logic [15:0] yc;
  } pix_t;

  pix_t       exp_q[$];
  pix_t       got_q[$];
  logic [7:0] m_y[4][64];
  logic [7:0] m_cb[64];
  logic [7:0] m_cr[64];
  int         cur_w, cur_h;
  int         checks = 0;
  int         failures = 0;
  int         last_first_valid, last_low_cnt;

  // Expected stream straight from the pixel rules: raster walk, crop, chroma index by halving.
  function automatic void build_expected(input logic [1:0] mode, input int ox, input int oy);
    int   n;
    pix_t p;
    exp_q.delete();
    n = (mode == YCBCR_420) ? 16 : 8;
    for (int yy = 0; yy < n; yy++) begin
      for (int xx = 0; xx < n; xx++) begin
        if (ox + xx < cur_w && oy + yy < cur_h) begin
          if (mode == YCBCR_420) begin
            p.y  = m_y[(yy / 8) * 2 + xx / 8][(yy % 8) * 8 + xx % 8];
            p.cb = m_cb[(yy / 2) * 8 + xx / 2];
            p.cr = m_cr[(yy / 2) * 8 + xx / 2];
          end else begin
            p.y  = m_y[0][yy * 8 + xx];
            p.cb = (mode == JPEG_MONOCHROME) ? 8'h80 : m_cb[yy * 8 + xx];
            p.cr = (mode == JPEG_MONOCHROME) ? 8'h80 : m_cr[yy * 8 + xx];
          end
          p.x  = 16'(ox + xx);
          p.yc = 16'(oy + yy);
          exp_q.push_back(p);
        end
      end
    end
  endfunction

  task automatic start_image(input logic [1:0] mode, input int w, input int h);
    img_mode   = mode;
    img_width  = 16'(w);
    img_height = 16'(h);
    cur_w      = w;
    cur_h      = h;
    img_start  = 1'b1;
    @(posedge clk); #1;
    img_start  = 1'b0;
  endtask

  // order: 0 ascending, 1 reversed, 2 random shuffle
  task automatic send_block(input logic [1:0] typ, input int bx, input int by, input int slot,
                            input int order, input int nsamp, input string name);
    int perm[64];
    int j, t, bad_acc, bad_out;
    bad_acc = 0;
    bad_out = 0;
    for (int i = 0; i < 64; i++) perm[i] = (order == 1) ? 63 - i : i;
    if (order == 2) begin
      for (int i = 63; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
    end
    for (int k = 0; k < nsamp; k++) begin
      inport_valid = 1'b1;
      inport_idx   = 6'(perm[k]);
      inport_id    = {typ, 14'(by), 16'(bx)};
      case (typ)
        BLOCK_Y:  inport_data = m_y[slot][perm[k]];
        BLOCK_CB: inport_data = m_cb[perm[k]];
        BLOCK_CR: inport_data = m_cr[perm[k]];
        default:  inport_data = 8'($urandom);
      endcase
      @(negedge clk);
      if (inport_accept !== 1'b1) bad_acc++;
      if (outport_valid !== 1'b0 || mcu_done !== 1'b0) bad_out++;
      @(posedge clk); #1;
    end
    inport_valid = 1'b0;
    checks++;
    if (bad_acc != 0) begin
      failures++;
      $display("[TB] FAIL %s input accept: %0d samples saw accept low, required 0", name, bad_acc);
    end
    checks++;
    if (bad_out != 0) begin
      failures++;
      $display("[TB] FAIL %s quiet output: %0d cycles with valid/done high, required 0", name, bad_out);
    end
  endtask

  task automatic drain(input bit stall, input string name);
    int   done_cnt, acc_bad, stab_bad, low_cnt, first_valid;
    bit   finished, prev_hold;
    pix_t cur, held;
    done_cnt = 0; acc_bad = 0; stab_bad = 0; low_cnt = 0; first_valid = -1;
    finished = 1'b0; prev_hold = 1'b0; held = '0;
    got_q.delete();
    for (int cyc = 0; cyc < DRAIN_BUDGET && !finished; cyc++) begin
      outport_accept = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cur = {outport_y, outport_cb, outport_cr, outport_px_x, outport_px_y};
      if (prev_hold && (outport_valid !== 1'b1 || cur !== held)) stab_bad++;
      if (mcu_done === 1'b1) begin
        done_cnt++;
        finished = 1'b1;
      end else begin
        if (inport_accept !== 1'b0) acc_bad++;
        if (outport_valid !== 1'b1) low_cnt++;
      end
      if (outport_valid === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        if (outport_accept) got_q.push_back(cur);
      end
      prev_hold = (outport_valid === 1'b1) && !outport_accept;
      held = cur;
      @(posedge clk); #1;
    end
    outport_accept = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mcu_done === 1'b1) done_cnt++;
      @(posedge clk); #1;
    end
    last_first_valid = first_valid;
    last_low_cnt     = low_cnt;
    checks++;
    if (!finished) begin
      failures++;
      $display("[TB] FAIL %s drain end: no mcu_done within %0d cycles", name, DRAIN_BUDGET);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("[TB] FAIL %s done pulses: got %0d, required 1", name, done_cnt);
    end
    checks++;
    if (acc_bad != 0) begin
      failures++;
      $display("[TB] FAIL %s accept during drain: high on %0d cycles, required 0", name, acc_bad);
    end
    checks++;
    if (stab_bad != 0) begin
      failures++;
      $display("[TB] FAIL %s stall stability: %0d changes while stalled, required 0", name, stab_bad);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("[TB] FAIL %s pixel count: got %0d, required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("[TB] FAIL %s pixel %0d: got (%0d,%0d) %h/%h/%h, required (%0d,%0d) %h/%h/%h",
                 name, i, got_q[i].x, got_q[i].yc, got_q[i].y, got_q[i].cb, got_q[i].cr,
                 exp_q[i].x, exp_q[i].yc, exp_q[i].y, exp_q[i].cb, exp_q[i].cr);
      end
    end
  endtask

  task automatic randomize_model();
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 4; k++) m_y[k][i] = 8'($urandom);
      m_cb[i] = 8'($urandom);
      m_cr[i] = 8'($urandom);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (outport_valid !== 1'b0 || mcu_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset flags: valid=%b done=%b, required 0/0", outport_valid, mcu_done);
    end
    checks++;
    if (inport_accept !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset accept: got %b, required 1", inport_accept);
    end
    checks++;
    if ({outport_y, outport_cb, outport_cr, outport_px_x, outport_px_y} !== 56'd0) begin
      failures++;
      $display("[TB] FAIL reset data: got %h/%h/%h (%0d,%0d), required all 0",
               outport_y, outport_cb, outport_cr, outport_px_x, outport_px_y);
    end
  endtask

  task automatic test_mono();
    start_image(JPEG_MONOCHROME, 8, 8);
    for (int i = 0; i < 64; i++) m_y[0][i] = 8'(i);
    send_block(BLOCK_Y, 0, 0, 0, 1, 64, "mono Y");
    build_expected(JPEG_MONOCHROME, 0, 0);
    drain(1'b0, "mono");
    checks++;
    if (last_first_valid != 2) begin
      failures++;
      $display("[TB] FAIL mono first valid latency: got %0d, required 2", last_first_valid);
    end
  endtask

  task automatic test_444_crop();
    start_image(YCBCR_444, 12, 8);
    for (int i = 0; i < 64; i++) begin
      m_y[0][i] = 8'h10; m_cb[i] = 8'h20; m_cr[i] = 8'h30;
    end
    send_block(BLOCK_Y, 0, 0, 0, 2, 64, "444 mcu0 Y");
    send_block(BLOCK_CB, 0, 0, 0, 2, 64, "444 mcu0 Cb");
    send_block(BLOCK_CR, 0, 0, 0, 2, 64, "444 mcu0 Cr");
    build_expected(YCBCR_444, 0, 0);
    drain(1'b0, "444 mcu0");
    send_block(BLOCK_EOF, 0, 0, 0, 2, 64, "eof");
    send_block(BLOCK_Y, 1, 0, 0, 2, 64, "444 mcu1 Y");
    send_block(BLOCK_CB, 1, 0, 0, 2, 64, "444 mcu1 Cb");
    send_block(BLOCK_CR, 1, 0, 0, 2, 64, "444 mcu1 Cr");
    build_expected(YCBCR_444, 8, 0);
    drain(1'b0, "444 mcu1");
    checks++;
    if (last_low_cnt != 34) begin
      failures++;
      $display("[TB] FAIL 444 crop idle cycles: got %0d, required 34", last_low_cnt);
    end
  endtask

  task automatic test_420();
    bit found;
    start_image(YCBCR_420, 16, 16);
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 4; k++) m_y[k][i] = 8'(8'h40 + k);
      m_cb[i] = 8'(i);
      m_cr[i] = 8'(63 - i);
    end
    for (int k = 0; k < 4; k++) send_block(BLOCK_Y, k & 1, k >> 1, k, 2, 64, "420 Y");
    send_block(BLOCK_CB, 0, 0, 0, 2, 64, "420 Cb");
    send_block(BLOCK_CR, 0, 0, 0, 2, 64, "420 Cr");
    build_expected(YCBCR_420, 0, 0);
    drain(1'b0, "420");
    found = 1'b0;
    foreach (got_q[i]) begin
      if (got_q[i].x == 16'd9 && got_q[i].yc == 16'd2) begin
        found = 1'b1;
        checks++;
        if ({got_q[i].y, got_q[i].cb, got_q[i].cr} !== {8'h41, 8'd12, 8'd51}) begin
          failures++;
          $display("[TB] FAIL 420 pixel (9,2): got %h/%h/%h, required 41/0c/33",
                   got_q[i].y, got_q[i].cb, got_q[i].cr);
        end
      end
      if (got_q[i].x == 16'd15 && got_q[i].yc == 16'd15) begin
        checks++;
        if ({got_q[i].y, got_q[i].cb, got_q[i].cr} !== {8'h43, 8'd63, 8'd0}) begin
          failures++;
          $display("[TB] FAIL 420 pixel (15,15): got %h/%h/%h, required 43/3f/00",
                   got_q[i].y, got_q[i].cb, got_q[i].cr);
        end
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL 420 pixel (9,2) present: got none, required one");
    end
  endtask

  task automatic test_backpressure();
    start_image(YCBCR_444, 8, 8);
    randomize_model();
    send_block(BLOCK_Y, 0, 0, 0, 2, 64, "stall Y");
    send_block(BLOCK_CB, 0, 0, 0, 2, 64, "stall Cb");
    send_block(BLOCK_CR, 0, 0, 0, 2, 64, "stall Cr");
    build_expected(YCBCR_444, 0, 0);
    drain(1'b1, "444 stall");
  endtask

  task automatic test_random_420();
    start_image(YCBCR_420, 16 + $urandom_range(1, 16), 16 + $urandom_range(1, 16));
    randomize_model();
    for (int k = 0; k < 4; k++) send_block(BLOCK_Y, 2 + (k & 1), 2 + (k >> 1), k, 2, 64, "rnd420 Y");
    send_block(BLOCK_CB, 1, 1, 0, 2, 64, "rnd420 Cb");
    send_block(BLOCK_CR, 1, 1, 0, 2, 64, "rnd420 Cr");
    build_expected(YCBCR_420, 16, 16);
    drain(1'b1, "420 random crop stall");
  endtask

  task automatic test_unsupported();
    int bad;
    start_image(UNSUPPORTED, 8, 8);
    send_block(BLOCK_Y, 0, 0, 0, 0, 64, "mode3 Y");
    send_block(BLOCK_CR, 0, 0, 0, 0, 64, "mode3 Cr");
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (outport_valid !== 1'b0 || mcu_done !== 1'b0 || inport_accept !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL mode3 stays in fill: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_abort();
    int n, bad;
    bit hit;
    start_image(JPEG_MONOCHROME, 8, 8);
    randomize_model();
    send_block(BLOCK_Y, 0, 0, 0, 2, 64, "abort Y");
    n = 0;
    hit = 1'b0;
    outport_accept = 1'b1;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (outport_valid === 1'b1) n++;
      if (n == 10) begin
        hit = 1'b1;
        img_start = 1'b1;
      end
      @(posedge clk); #1;
    end
    img_start = 1'b0;
    checks++;
    if (!hit) begin
      failures++;
      $display("[TB] FAIL abort reach pixel 10: got %0d pixels, required 10", n);
    end
    checks++;
    if (outport_valid !== 1'b0 || mcu_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort next cycle: valid=%b done=%b, required 0/0", outport_valid, mcu_done);
    end
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (outport_valid !== 1'b0 || mcu_done !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL abort quiet: %0d cycles with valid/done, required 0", bad);
    end
    randomize_model();
    send_block(BLOCK_Y, 0, 0, 0, 2, 64, "post-abort Y");
    build_expected(JPEG_MONOCHROME, 0, 0);
    drain(1'b0, "post-abort mono");
  endtask

  task automatic test_async_reset();
    send_block(BLOCK_Y, 0, 0, 0, 2, 20, "partial Y");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({outport_valid, mcu_done, inport_accept} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL async reset flags: valid/done/accept=%b%b%b, required 001",
               outport_valid, mcu_done, inport_accept);
    end
    checks++;
    if ({outport_y, outport_cb, outport_cr, outport_px_x, outport_px_y} !== 56'd0) begin
      failures++;
      $display("[TB] FAIL async reset data: got %h/%h/%h (%0d,%0d), required all 0",
               outport_y, outport_cb, outport_cr, outport_px_x, outport_px_y);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_image(JPEG_MONOCHROME, 8, 8);
    randomize_model();
    send_block(BLOCK_Y, 0, 0, 0, 2, 64, "post-reset Y");
    build_expected(JPEG_MONOCHROME, 0, 0);
    drain(1'b0, "post-reset mono");
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; img_start = 1'b0; img_mode = JPEG_MONOCHROME;
    img_width = 16'd8; img_height = 16'd8; cur_w = 8; cur_h = 8;
    inport_valid = 1'b0; inport_data = '0; inport_idx = '0; inport_id = '0;
    outport_accept = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_mono();
    test_444_crop();
    test_420();
    test_backpressure();
    test_random_420();
    test_unsupported();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
